// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: FSM state codes,
// access-size encodings and the lane alignment / extension helpers.
package lsu_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [3:0] gen_wmask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    gen_wmask = 4'b0001 << off;
      SZ_H:    gen_wmask = 4'b0011 << off;
      SZ_W:    gen_wmask = 4'b1111;
      default: gen_wmask = 4'b0000;
    endcase
  endfunction

  // Data is replicated into every lane; the byte mask picks the live ones.
  function automatic logic [31:0] align_wdata(input logic [1:0] size, input logic [1:0] off,
                                              input logic [31:0] d);
    logic [1:0] unused_off;
    unused_off = off;
    case (size)
      SZ_B:    align_wdata = {4{d[7:0]}};
      SZ_H:    align_wdata = {2{d[15:0]}};
      default: align_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] extract_rdata(input logic [1:0] size, input logic [1:0] off,
                                                input logic uns, input logic [31:0] w);
    logic [31:0] lane;
    lane = w >> {off, 3'b000};
    case (size)
      SZ_B:    extract_rdata = uns ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    extract_rdata = uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: extract_rdata = lane;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: store byte mask and replicated store data,
// load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  // Pure function of the latched request and the SRAM read word.
  always_comb begin
    o_wmask = gen_wmask(i_size, i_off);
    o_wdata = align_wdata(i_size, i_off, i_wdata);
    o_rdata = extract_rdata(i_size, i_off, i_uns, i_rdata);
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the data SRAM port. One request in flight:
// IDLE accepts, REQ drives the SRAM until mem_valid, RESP holds the result
// until consumed. Optional REQ timeout is built when LSU_TIMEOUT_EN is defined.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  logic [1:0]  r_state;
  logic        r_wen;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_misaligned;
  logic        w_in_req;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] r_tmo;
`endif

  lsu_align u_align (
    .i_size  (r_size),
    .i_off   (r_addr[1:0]),
    .i_uns   (r_uns),
    .i_wdata (r_wdata),
    .i_rdata (mem_rdata),
    .o_wmask (w_wmask),
    .o_wdata (w_wdata),
    .o_rdata (w_ext)
  );

  // Misalignment/illegal size decode on the incoming request.
  always_comb begin
    w_misaligned = (req_size == 2'd3) ||
                   ((req_size == SZ_H) && req_addr[0]) ||
                   ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  end

  // SRAM strobes only live in REQ; elsewhere the port is a masked no-op.
  always_comb begin
    w_in_req   = (r_state == S_REQ);
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    resp_rdata = r_rdata;
    resp_err   = r_err;
    mem_ren    = w_in_req && !r_wen;
    mem_wen    = w_in_req && r_wen;
    mem_wmask  = {4'b0000, (w_in_req ? w_wmask : 4'b0000)};
    mem_addr   = {r_addr[31:2], 2'b00};
    mem_wdata  = w_wdata;
  end

  // FSM with request latch and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wen   <= 1'b0;
      r_size  <= SZ_B;
      r_uns   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_tmo   <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_wen   <= req_wen;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= 32'd0;
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_err   <= 1'b0;
              r_state <= S_REQ;
`ifdef LSU_TIMEOUT_EN
              r_tmo   <= 8'd0;
`endif
            end
          end
        end
        S_REQ: begin
          if (mem_valid) begin
            r_rdata <= r_wen ? 32'd0 : w_ext;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_tmo == TMO_LAST) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master; with LSU_TIMEOUT_EN it builds TIMEOUT_CYC=4.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  lsu_mem_master #(.TIMEOUT_CYC(4)) dut (
`else
  lsu_mem_master dut (
`endif
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single accepting edge.
  task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  // Give the SRAM completion for one cycle.
  task automatic complete(input logic [31:0] rdata);
    mem_rdata = rdata; mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_ren, mem_wen} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 10000", {req_ready, resp_valid, resp_err, mem_ren, mem_wen});
    end
    checks++;
    if ({resp_rdata, mem_addr, mem_wdata, mem_wmask} !== 104'd0) begin
      errors++; $display("FAIL reset_data rdata %h addr %h wdata %h wmask %h exp all 0", resp_rdata, mem_addr, mem_wdata, mem_wmask);
    end
  endtask

  task automatic load_case(input string name, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] word, input logic [31:0] exp);
    issue(1'b0, size, uns, addr, 32'd0);
    checks++;
    if ({mem_ren, mem_wen, req_ready, resp_valid} !== 4'b1000 || mem_addr !== {addr[31:2], 2'b00}) begin
      errors++; $display("FAIL %s_req ren/wen/rdy/rv %b addr %h exp 1000 %h", name, {mem_ren, mem_wen, req_ready, resp_valid}, mem_addr, {addr[31:2], 2'b00});
    end
    complete(word);
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== exp || mem_ren !== 1'b0) begin
      errors++; $display("FAIL %s_resp rv %b err %b rdata %h ren %b exp 1 0 %h 0", name, resp_valid, resp_err, resp_rdata, mem_ren, exp);
    end
    drain();
  endtask

  task automatic test_load();
    load_case("lb_s3", 2'd0, 1'b0, 32'h8000_0003, 32'h80AA_BBCC, 32'hFFFF_FF80);
    load_case("lbu_1", 2'd0, 1'b1, 32'h8000_0001, 32'h80AA_BBCC, 32'h0000_00BB);
    load_case("lh_s2", 2'd1, 1'b0, 32'h8000_0002, 32'h80AA_BBCC, 32'hFFFF_80AA);
    load_case("lhu_2", 2'd1, 1'b1, 32'h8000_0002, 32'h80AA_BBCC, 32'h0000_80AA);
    load_case("lh_s0", 2'd1, 1'b0, 32'h0000_0010, 32'h80AA_3BCC, 32'h0000_3BCC);
    load_case("lw", 2'd2, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
  endtask

  task automatic store_case(input string name, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [7:0] exp_mask, input logic [31:0] exp_wdata);
    issue(1'b1, size, 1'b0, addr, wdata);
    checks++;
    if ({mem_ren, mem_wen} !== 2'b01 || mem_wmask !== exp_mask || mem_wdata !== exp_wdata ||
        mem_addr !== {addr[31:2], 2'b00}) begin
      errors++; $display("FAIL %s_req ren/wen %b mask %h wdata %h addr %h exp 01 %h %h", name, {mem_ren, mem_wen}, mem_wmask, mem_wdata, mem_addr, exp_mask, exp_wdata);
    end
    complete(32'hFFFF_FFFF);
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'd0 || mem_wen !== 1'b0 || mem_wmask !== 8'h00) begin
      errors++; $display("FAIL %s_resp rv %b err %b rdata %h wen %b mask %h exp 1 0 0 0 0", name, resp_valid, resp_err, resp_rdata, mem_wen, mem_wmask);
    end
    drain();
  endtask

  task automatic test_store();
    store_case("sh_2", 2'd1, 32'h8000_0002, 32'h1234_5678, 8'h0C, 32'h5678_5678);
    store_case("sb_1", 2'd0, 32'h8000_0001, 32'h0000_00AB, 8'h02, 32'hABAB_ABAB);
    store_case("sb_3", 2'd0, 32'h8000_0007, 32'h1111_11C3, 8'h08, 32'hC3C3_C3C3);
    store_case("sw", 2'd2, 32'h8000_0004, 32'hCAFE_F00D, 8'h0F, 32'hCAFE_F00D);
  endtask

  task automatic err_case(input string name, input logic wen, input logic [1:0] size, input logic [31:0] addr);
    issue(wen, size, 1'b0, addr, 32'h5555_AAAA);
    checks++;
    if ({mem_ren, mem_wen, mem_wmask} !== 10'd0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
      errors++; $display("FAIL %s ren/wen %b mask %h rv %b err %b rdata %h exp 00 00 1 1 0", name, {mem_ren, mem_wen}, mem_wmask, resp_valid, resp_err, resp_rdata);
    end
    drain();
  endtask

  task automatic test_misaligned();
    err_case("lw_mis", 1'b0, 2'd2, 32'h8000_0001);
    err_case("sw_mis2", 1'b1, 2'd2, 32'h8000_0002);
    err_case("lh_mis", 1'b0, 2'd1, 32'h8000_0003);
    err_case("sz3", 1'b0, 2'd3, 32'h8000_0000);
  endtask

  task automatic test_wait_state();
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_ren !== 1'b1 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL wait_req cyc %0d ren %b rv %b exp 1 0", i, mem_ren, resp_valid);
      end
    end
    complete(32'h0BAD_F00D);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL wait_resp rv %b rdata %h exp 1 0badf00d", resp_valid, resp_rdata);
    end
    drain();
  endtask

  task automatic test_resp_hold();
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0002, 32'd0);
    complete(32'h0077_0000);
    // Competing request and stray mem_valid while the response is held.
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0100;
    mem_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0077 || req_ready !== 1'b0 || mem_wen !== 1'b0) begin
        errors++; $display("FAIL hold cyc %0d rv %b rdata %h rdy %b wen %b exp 1 00000077 0 0", i, resp_valid, resp_rdata, req_ready, mem_wen);
      end
    end
    mem_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL hold_release rv %b rdy %b wen %b exp 0 1 0", resp_valid, req_ready, mem_wen);
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 2'd2, 1'b0, 32'h8000_0008, 32'h1234_5678);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, mem_ren, mem_wen} !== 4'b1000 || mem_wmask !== 8'h00 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      errors++; $display("FAIL rst_mid rdy/rv/ren/wen %b mask %h addr %h wdata %h exp 1000 0 0 0", {req_ready, resp_valid, mem_ren, mem_wen}, mem_wmask, mem_addr, mem_wdata);
    end
    tick();
    rst = 1'b1;
    mem_valid = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_valid = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_err !== 1'b0) begin
      errors++; $display("FAIL rst_after rv %b rdy %b err %b exp 0 1 0", resp_valid, req_ready, resp_err);
    end
  endtask

  task automatic test_timeout();
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'd0);
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_ren !== 1'b1 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL tmo_req cyc %0d ren %b rv %b exp 1 0", i, mem_ren, resp_valid);
      end
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0 || mem_ren !== 1'b0) begin
      errors++; $display("FAIL tmo_resp rv %b err %b rdata %h ren %b exp 1 1 0 0", resp_valid, resp_err, resp_rdata, mem_ren);
    end
    complete(32'h9999_9999);
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
      errors++; $display("FAIL tmo_late rv %b err %b rdata %h exp 1 1 0", resp_valid, resp_err, resp_rdata);
    end
`else
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (mem_ren !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL no_tmo ren %b rv %b exp 1 0", mem_ren, resp_valid);
    end
    complete(32'h0000_4242);
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0000_4242) begin
      errors++; $display("FAIL no_tmo_resp rv %b err %b rdata %h exp 1 0 00004242", resp_valid, resp_err, resp_rdata);
    end
`endif
    drain();
  endtask

  initial begin
    #12;
    test_reset();
    rst = 1'b1;
    tick();
    test_load();
    test_store();
    test_misaligned();
    test_wait_state();
    test_resp_hold();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
